// File: rtl/div_hilo_ctrl.sv
// Issue/writeback controller for the signed divider: stalls the pipeline while a
// DIV is in flight and owns the architectural HI/LO registers (DIV, MTHI, MTLO).
module div_hilo_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_stall,
    input  logic        abort,
    input  logic        op_div,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_start,
    input  logic        div_busy,
    input  logic        div_finish,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        stall_req,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic latch_ops;
    logic write_hi;
    logic write_lo;
    logic write_res;
    logic divisor_nz;

    assign divisor_nz = (rt_val != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        stall_req = 1'b0;
        latch_ops = 1'b0;
        write_hi  = 1'b0;
        write_lo  = 1'b0;
        write_res = 1'b0;

        unique case (state)
            IDLE: begin
                stall_req = op_div && divisor_nz && !abort;
                if (op_div && !cpu_stall && !abort) begin
                    // A zero divisor is latched but never issued; HI/LO stay as they are.
                    latch_ops = 1'b1;
                    if (divisor_nz) begin
                        state_nxt = ISSUE;
                    end
                end else if (!op_div) begin
                    write_hi = op_mthi && !cpu_stall;
                    write_lo = op_mtlo && !cpu_stall;
                end
            end
            ISSUE: begin
                stall_req = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!div_busy) begin
                    div_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall_req = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (div_finish) begin
                    write_res = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // State may still be ISSUE/WAIT while reset is held before its edge.
        if (reset) begin
            div_start = 1'b0;
            stall_req = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (latch_ops) begin
            div_dividend <= rs_val;
            div_divisor  <= rt_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (write_res) begin
            lo_o <= div_q;
            hi_o <= div_r;
        end else begin
            if (write_hi) begin
                hi_o <= rs_val;
            end
            if (write_lo) begin
                lo_o <= rs_val;
            end
        end
    end

endmodule
